sqrt_iterative: RTL

- Sequential digit-by-digit (restoring, radix-4 pair) integer square-root unit.
- Produces one root bit per clock.
- Its root is the square-root operand presented to the result multiplexer, alongside the divider and multiplier results.
- Start/done handshake toward the top-level operation controller.

---
 rtl/sqrt_iterative_pkg.sv | 27 ++
 rtl/sqrt_iterative_step.sv | 28 ++
 rtl/sqrt_iterative.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sqrt_iterative_pkg.sv
// Shared types and constants for the integer square-root unit and the
// surrounding operation controller / result multiplexer.
package sqrt_iterative_pkg;

  // Square-root sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqrt_state_t;

  // Operation select shared by the controller and the result multiplexer
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_SQRT = 2'b10;

  // Root is half the radicand width
  function automatic int root_width(input int nbits);
    return nbits / 2;
  endfunction

  // Remainder needs one extra bit: it can reach 2*root
  function automatic int rem_width(input int nbits);
    return nbits / 2 + 1;
  endfunction

endpackage

// File: rtl/sqrt_iterative_step.sv
// One restoring radix-4 iteration: brings in the next radicand bit pair,
// tries to subtract the trial value (4Q+1) and appends one root bit.
module sqrt_step #(
  parameter int RootW = 8
) (
  input  logic [RootW+1:0] rem_in,
  input  logic [RootW-1:0] root_in,
  input  logic [1:0]       bit_pair,
  output logic [RootW+1:0] rem_next,
  output logic [RootW-1:0] root_next
);

  logic [RootW+1:0] rem_shifted;
  logic [RootW+1:0] trial;
  logic [RootW+1:0] diff;
  logic             fits;

  // Shift in the bit pair, compare against 4Q+1, restore when it does not fit
  always_comb begin
    rem_shifted = (rem_in << 2) | {{RootW{1'b0}}, bit_pair};
    trial       = {root_in, 2'b01};
    fits        = (rem_shifted >= trial);
    diff        = rem_shifted - trial;
    rem_next    = fits ? diff : rem_shifted;
    root_next   = (root_in << 1) | {{(RootW-1){1'b0}}, fits};
  end

endmodule

// File: rtl/sqrt_iterative.sv
// Sequential digit-by-digit integer square root, one root bit per clock.
// Results are registered on the last iteration edge and held until the
// next computation completes.
module sqrt_iterative
  import sqrt_iterative_pkg::*;
#(
  parameter int NBits = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NBits-1:0]            radicand,
  output logic                        ready,
  output logic                        busy,
  output logic                        done,
  output logic [root_width(NBits)-1:0] root,
  output logic [rem_width(NBits)-1:0]  remainder
);

  localparam int RootW = root_width(NBits);
  localparam int RemW  = rem_width(NBits);
  localparam int CntW  = (RootW > 1) ? $clog2(RootW) : 1;
  localparam logic [CntW-1:0] LastIter = CntW'(RootW - 1);

  sqrt_state_t      state_reg;
  sqrt_state_t      state_next;
  logic [CntW-1:0]  count_reg;
  logic [NBits-1:0] operand_reg;
  logic [RootW+1:0] work_rem_reg;
  logic [RootW-1:0] work_root_reg;
  logic [RootW-1:0] root_reg;
  logic [RemW-1:0]  rem_reg;

  logic [RootW+1:0] step_rem_next;
  logic [RootW-1:0] step_root_next;
  logic             last_iter;

  assign last_iter = (count_reg == LastIter);

  sqrt_step #(
    .RootW (RootW)
  ) u_step (
    .rem_in    (work_rem_reg),
    .root_in   (work_root_reg),
    .bit_pair  (operand_reg[NBits-1 -: 2]),
    .rem_next  (step_rem_next),
    .root_next (step_root_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in CALC, publish on the last iteration
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg     <= '0;
      operand_reg   <= '0;
      work_rem_reg  <= '0;
      work_root_reg <= '0;
      root_reg      <= '0;
      rem_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            operand_reg   <= radicand;
            work_rem_reg  <= '0;
            work_root_reg <= '0;
            count_reg     <= '0;
          end
        end
        CALC: begin
          work_rem_reg  <= step_rem_next;
          work_root_reg <= step_root_next;
          operand_reg   <= operand_reg << 2;
          count_reg     <= count_reg + CntW'(1);
          if (last_iter) begin
            root_reg <= step_root_next;
            // Final remainder is bounded by 2*root, so the top bit is always zero
            rem_reg  <= RemW'(step_rem_next);
          end
        end
        default: ;
      endcase
    end
  end

  assign root      = root_reg;
  assign remainder = rem_reg;

endmodule
